sram_req_arbiter: RTL and testbench

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

---
 rtl/sram_req_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_req_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-requester (inst/data) arbiter onto one sram-like master port, one transaction in flight.
// Tie-break: fixed data priority by default; define ARB_ROUND_ROBIN_EN for alternating grants.
module sram_req_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // inst requester
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_wdata,
  input  logic              inst_uncached,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  // data requester
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic              data_uncached,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  // downstream master
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic              m_uncached,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [31:0]       m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;  // 1 = data requester owns the port
  logic   grant;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b0;
    else if (state == S_IDLE && (inst_req || data_req))
      last_grant <= grant;
  end

  // On a tie, hand the port to whoever did not get it last time.
  assign grant = (inst_req && data_req) ? ~last_grant : data_req;
`else
  assign grant = data_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    m_req        = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    busy         = 1'b0;
    case (state)
      S_IDLE: begin
        if (inst_req || data_req) begin
          owner_nxt = grant;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        m_req = 1'b1;
        busy  = 1'b1;
        if (m_addr_ok) begin
          inst_addr_ok = ~owner;
          data_addr_ok = owner;
          state_nxt    = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (m_data_ok) begin
          inst_data_ok = ~owner;
          data_data_ok = owner;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Reset silences every handshake output in the same cycle it is asserted.
    if (rst) begin
      m_req        = 1'b0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      busy         = 1'b0;
    end
  end

  always_comb begin
    m_wr       = 1'b0;
    m_size     = 2'd0;
    m_addr     = '0;
    m_wdata    = 32'd0;
    m_uncached = 1'b0;
    if (m_req) begin
      m_wr       = owner ? data_wr       : inst_wr;
      m_size     = owner ? data_size     : inst_size;
      m_addr     = owner ? data_addr     : inst_addr;
      m_wdata    = owner ? data_wdata    : inst_wdata;
      m_uncached = owner ? data_uncached : inst_uncached;
    end
  end

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: per-cycle vector table plus hand sequences
// for write-field stability, tie arbitration and reset during DATA.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, inst_uncached, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_uncached, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        m_req, m_wr, m_uncached, m_addr_ok, m_data_ok, busy;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int n_cmp = 0;
  int n_err = 0;

  sram_req_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_uncached(inst_uncached), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_uncached(data_uncached), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_uncached(m_uncached), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic        mreq, iaok, daok, idok, ddok, busy;
    logic [31:0] maddr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic r, ir, dr, ao, dk, input logic [31:0] rd,
                             input logic mr, ia, da, id, dd, b, input logic [31:0] ma);
    vec_t t;
    t.rst = r; t.ireq = ir; t.dreq = dr; t.aok = ao; t.dok = dk; t.rdata = rd;
    t.mreq = mr; t.iaok = ia; t.daok = da; t.idok = id; t.ddok = dd; t.busy = b; t.maddr = ma;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [31:0] IA = 32'hBFC0_0000;
  localparam logic [31:0] DA = 32'h8000_1004;

  logic grants[$];
  logic exp_g[4];
  int   dok_cnt;

  initial begin
    // Vector table: one entry per cycle, inputs driven at negedge, outputs checked 1ns later.
    vq.push_back(v(1,1,0,0,0,32'h1111_1111, 0,0,0,0,0,0, 0));   // reset state
    vq.push_back(v(0,0,0,0,1,32'h2222_2222, 0,0,0,0,0,0, 0));   // stray data_ok in IDLE
    vq.push_back(v(0,1,0,0,0,32'h0,         0,0,0,0,0,0, 0));   // inst req seen, no issue yet
    vq.push_back(v(0,1,0,0,0,32'h0,         1,0,0,0,0,1, IA));
    vq.push_back(v(0,1,0,0,1,32'h55,        1,0,0,0,0,1, IA));  // data_ok in ADDR dropped
    vq.push_back(v(0,1,0,1,0,32'h0,         1,1,0,0,0,1, IA));
    vq.push_back(v(0,0,0,0,0,32'h0,         0,0,0,0,0,1, 0));
    vq.push_back(v(0,0,0,0,0,32'h0,         0,0,0,0,0,1, 0));
    vq.push_back(v(0,0,0,0,1,32'h3C08_BFC0, 0,0,0,1,0,1, 0));
    vq.push_back(v(0,0,0,0,0,32'h0,         0,0,0,0,0,0, 0));
    vq.push_back(v(0,1,0,0,0,32'h0,         0,0,0,0,0,0, 0));   // inst then data queued behind
    vq.push_back(v(0,1,0,1,0,32'h0,         1,1,0,0,0,1, IA));
    vq.push_back(v(0,0,1,0,0,32'h0,         0,0,0,0,0,1, 0));
    vq.push_back(v(0,0,1,0,1,32'hA5A5_A5A5, 0,0,0,1,0,1, 0));
    vq.push_back(v(0,0,1,0,0,32'h0,         0,0,0,0,0,0, 0));   // mandatory IDLE gap
    vq.push_back(v(0,0,1,1,0,32'h0,         1,0,1,0,0,1, DA));
    vq.push_back(v(0,0,0,0,1,32'h5A5A_5A5A, 0,0,0,0,1,1, 0));
    vq.push_back(v(0,0,0,0,0,32'h0,         0,0,0,0,0,0, 0));
    vq.push_back(v(0,0,1,0,0,32'h0,         0,0,0,0,0,0, 0));   // owner drops req in ADDR
    vq.push_back(v(0,0,0,0,0,32'h0,         1,0,0,0,0,1, DA));
    vq.push_back(v(0,0,0,1,0,32'h0,         1,0,1,0,0,1, DA));
    vq.push_back(v(0,0,0,0,1,32'h0,         0,0,0,0,1,1, 0));

    rst = 1; inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    inst_wr = 0; inst_size = 2'd2; inst_addr = IA; inst_wdata = 0; inst_uncached = 0;
    data_wr = 0; data_size = 2'd2; data_addr = DA; data_wdata = 0; data_uncached = 0;
    repeat (2) @(negedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; inst_req = vq[i].ireq; data_req = vq[i].dreq;
      m_addr_ok = vq[i].aok; m_data_ok = vq[i].dok; m_rdata = vq[i].rdata;
      #1;
      chk($sformatf("v%0d m_req", i),        m_req,        vq[i].mreq);
      chk($sformatf("v%0d inst_addr_ok", i), inst_addr_ok, vq[i].iaok);
      chk($sformatf("v%0d data_addr_ok", i), data_addr_ok, vq[i].daok);
      chk($sformatf("v%0d inst_data_ok", i), inst_data_ok, vq[i].idok);
      chk($sformatf("v%0d data_data_ok", i), data_data_ok, vq[i].ddok);
      chk($sformatf("v%0d busy", i),         busy,         vq[i].busy);
      chk($sformatf("v%0d inst_rdata", i),   inst_rdata,   vq[i].rdata);
      chk($sformatf("v%0d data_rdata", i),   data_rdata,   vq[i].rdata);
      if (vq[i].mreq) chk($sformatf("v%0d m_addr", i), m_addr, vq[i].maddr);
    end

    // Data write: fields come from the data requester and hold until m_addr_ok.
    @(negedge clk);
    m_addr_ok = 0; m_data_ok = 0;
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = DA;
    data_wdata = 32'hDEAD_BEEF; data_uncached = 1;
    inst_wr = 0; inst_size = 2'd1; inst_wdata = 32'h1234_5678; inst_uncached = 0;
    #1 chk("wr idle m_req", m_req, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_addr_ok = (k == 2);
      #1;
      chk($sformatf("wr%0d m_req", k),      m_req,      1);
      chk($sformatf("wr%0d m_wr", k),       m_wr,       1);
      chk($sformatf("wr%0d m_addr", k),     m_addr,     DA);
      chk($sformatf("wr%0d m_wdata", k),    m_wdata,    32'hDEAD_BEEF);
      chk($sformatf("wr%0d m_size", k),     m_size,     2);
      chk($sformatf("wr%0d m_uncached", k), m_uncached, 1);
      chk($sformatf("wr%0d data_addr_ok", k), data_addr_ok, (k == 2));
    end
    @(negedge clk);
    data_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #1 chk("wr data_data_ok", data_data_ok, 1);
    chk("wr inst_data_ok", inst_data_ok, 0);
    data_wr = 0; data_uncached = 0; data_wdata = 0; inst_size = 2'd2;

    // Tie arbitration: both requests held through 4 transactions, starting from reset.
    @(negedge clk);
    rst = 1; inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
    #1 chk("rst m_req", m_req, 0);
    chk("rst busy", busy, 0);
    chk("rst data_ok", {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}, 0);
    @(negedge clk);
    rst = 0;
    dok_cnt = 0;
    for (int c = 0; c < 20 && grants.size() < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (inst_addr_ok || data_addr_ok) grants.push_back(data_addr_ok);
      if (inst_data_ok || data_data_ok) dok_cnt++;
    end
    chk("tie grant count", grants.size(), 4);
    chk("tie data_ok count", dok_cnt, 3);
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int g = 0; g < 4; g++)
      if (g < grants.size()) chk($sformatf("tie grant%0d is_data", g), grants[g], exp_g[g]);

    // Reset pulse while in DATA, then a late m_data_ok.
    @(negedge clk);
    rst = 1; inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 0;
    @(negedge clk);
    rst = 0; inst_req = 1;
    #1 chk("rd idle busy", busy, 0);
    @(negedge clk);
    m_addr_ok = 1;
    #1 chk("rd inst_addr_ok", inst_addr_ok, 1);
    @(negedge clk);
    inst_req = 0; m_addr_ok = 0;
    #1 chk("rd data busy", busy, 1);
    @(negedge clk);
    rst = 1;
    #1 chk("rd in-reset busy", busy, 0);
    @(negedge clk);
    rst = 0; m_data_ok = 1;
    #1 chk("late data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("late busy", busy, 0);
    chk("late m_req", m_req, 0);
    @(negedge clk);
    m_data_ok = 0; data_req = 1;
    #1 chk("post-reset idle m_req", m_req, 0);
    @(negedge clk);
    #1 chk("post-reset issue m_req", m_req, 1);
    chk("post-reset issue m_addr", m_addr, DA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
